mips_mc_control: RTL and testbench

Multi-cycle main control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and write-back, and drives every datapath mux select and write enable: register-destination 5-bit mux, ALU operand 32-bit muxes, memory-to-register mux, and PC source mux. A ready handshake stretches memory states for variable-latency memory. The block sits between the instruction register opcode field and the datapath control inputs.

---
 rtl/mips_mc_control.sv | 170 +++++++++++++++++
 tb/tb_mips_mc_control.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// mips_mc_control -- multi-cycle main control FSM for the MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back and drives every datapath
// mux select and write enable. Memory states stretch on mem_ready=0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (forces FETCH, gates enables)
//   opcode     IR[31:26] of the latched instruction
//   zero       ALU zero flag, used in BEQEX
//   mem_ready  memory completes the current access this cycle
//   mem_read, mem_write, iord            memory request / address select
//   ir_write, pc_en, pc_src              IR load, PC load and PC source select
//   reg_write, reg_dst, mem_to_reg       register file write port control
//   alu_src_a, alu_src_b, alu_op         ALU operand selects and operation
//   illegal    one-cycle pulse in DECODE on an unsupported opcode
//   state      current state code (debug)
module mips_mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_en;
  logic       w_reg_write;
  logic       w_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = FETCH;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    iord        = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_en     = 1'b0;
    pc_src      = 2'b00;
    w_reg_write = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    w_illegal   = 1'b0;
    case (r_state)
      FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = 2'b01;
        w_ir_write = mem_ready;
        w_pc_en    = mem_ready;
        w_next     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        w_mem_read = 1'b1;
        iord       = 1'b1;
        w_next     = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      MEMWR: begin
        w_mem_write = 1'b1;
        iord        = 1'b1;
        w_next      = mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = RTYPEWB;
      end
      RTYPEWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        w_pc_en   = zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = ADDIWB;
      end
      ADDIWB: w_reg_write = 1'b1;
      JEX: begin
        pc_src  = 2'b10;
        w_pc_en = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  // Reset already forces FETCH asynchronously, so selects show FETCH values;
  // only the request/enable strobes need explicit gating while rst is high.
  assign mem_read  = w_mem_read  & ~rst;
  assign mem_write = w_mem_write & ~rst;
  assign ir_write  = w_ir_write  & ~rst;
  assign pc_en     = w_pc_en     & ~rst;
  assign reg_write = w_reg_write & ~rst;
  assign illegal   = w_illegal   & ~rst;
  assign state     = r_state;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control -- self-checking bench for mips_mc_control.
// A per-instruction reference builds the expected state walk (phases plus
// memory wait cycles) and per-cycle control word; table vectors, random
// instructions and hand-written reset sequences are checked against it.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic       mr, mw, iord, irw, pce;
    logic [1:0] pcs;
    logic       rw, rd, m2r, a;
    logic [1:0] b, op;
    logic       ill;
    logic [3:0] st;
  } word_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } cyc_t;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    int unsigned wf;
    int unsigned wm;
    int          len;
    string       name;
  } vec_t;

  word_t base [12];
  cyc_t  q [$];
  int    checks = 0;
  int    errors = 0;

  function automatic word_t actual();
    word_t w;
    w = {mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
         mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, state};
    return w;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // Expected control word per state from the datapath control table.
  task automatic init_table();
    for (int unsigned i = 0; i < 12; i++) base[i] = '0;
    base[0].mr = 1;  base[0].b = 2'b01;
    base[1].b = 2'b11;
    base[2].a = 1;   base[2].b = 2'b10;
    base[3].mr = 1;  base[3].iord = 1;
    base[4].rw = 1;  base[4].m2r = 1;
    base[5].mw = 1;  base[5].iord = 1;
    base[6].a = 1;   base[6].op = 2'b10;
    base[7].rw = 1;  base[7].rd = 1;
    base[8].a = 1;   base[8].op = 2'b01; base[8].pcs = 2'b01;
    base[9].a = 1;   base[9].b = 2'b10;
    base[10].rw = 1;
    base[11].pcs = 2'b10; base[11].pce = 1;
    for (int unsigned i = 0; i < 12; i++) base[i].st = 4'(i);
  endtask

  task automatic push(input logic [3:0] st, input logic rdy);
    cyc_t c;
    c.st = st; c.rdy = rdy;
    q.push_back(c);
  endtask

  // Memory phase: w cycles with mem_ready low, then one completing cycle.
  task automatic push_mem(input logic [3:0] st, input int unsigned w);
    for (int unsigned i = 0; i < w; i++) push(st, 1'b0);
    push(st, 1'b1);
  endtask

  task automatic build(input logic [5:0] op, input int unsigned wf, input int unsigned wm);
    q.delete();
    push_mem(4'd0, wf);
    push(4'd1, 1'($urandom));
    case (op)
      6'b000000: begin push(4'd6, 1'($urandom)); push(4'd7, 1'($urandom)); end
      6'b100011: begin push(4'd2, 1'($urandom)); push_mem(4'd3, wm); push(4'd4, 1'($urandom)); end
      6'b101011: begin push(4'd2, 1'($urandom)); push_mem(4'd5, wm); end
      6'b000100: push(4'd8, 1'($urandom));
      6'b001000: begin push(4'd9, 1'($urandom)); push(4'd10, 1'($urandom)); end
      6'b000010: push(4'd11, 1'($urandom));
      default: ;
    endcase
  endtask

  // Entered just after a rising edge with the DUT in FETCH.
  task automatic run(input logic [5:0] op, input logic z, input int exp_len, input string tag);
    word_t e, a;
    int    end_cyc;
    logic [3:0] prev;
    opcode  = op;
    zero    = z;
    end_cyc = -1;
    prev    = state;
    for (int i = 0; i < q.size(); i++) begin
      mem_ready = q[i].rdy;
      e = base[q[i].st];
      if (q[i].st == 4'd0) begin e.irw = q[i].rdy; e.pce = q[i].rdy; end
      if (q[i].st == 4'd8) e.pce = z;
      if (q[i].st == 4'd1) e.ill = !legal(op);
      @(negedge clk);
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s cyc%0d word got %h exp %h (state got %0d exp %0d)",
                 tag, i, a, e, a.st, e.st);
      end
      @(posedge clk);
      #1;
      if (end_cyc < 0 && prev != 4'd0 && state == 4'd0) end_cyc = i + 1;
      prev = state;
    end
    checks++;
    if (end_cyc != exp_len) begin
      errors++;
      $display("FAIL %s length got %0d exp %0d", tag, end_cyc, exp_len);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  vec_t vecs [10];
  word_t rst_word;
  logic [5:0] ops [6];

  initial begin
    init_table();
    vecs[0] = '{6'b000000, 1'b0, 0, 0, 4, "rtype"};
    vecs[1] = '{6'b100011, 1'b0, 0, 2, 7, "lw_wait2"};
    vecs[2] = '{6'b000100, 1'b1, 0, 0, 3, "beq_taken"};
    vecs[3] = '{6'b000100, 1'b0, 0, 0, 3, "beq_not"};
    vecs[4] = '{6'b101011, 1'b0, 0, 0, 4, "sw"};
    vecs[5] = '{6'b000010, 1'b0, 0, 0, 3, "j"};
    vecs[6] = '{6'b111111, 1'b0, 0, 0, 2, "illegal"};
    vecs[7] = '{6'b001000, 1'b0, 0, 0, 4, "addi"};
    vecs[8] = '{6'b100011, 1'b1, 1, 0, 6, "lw_fwait"};
    vecs[9] = '{6'b101011, 1'b0, 2, 1, 7, "sw_waits"};
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    rst_word = '0;
    rst_word.b = 2'b01;
    rst = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    #1 rst = 1'b1;
    #2 chk("reset_async", 32'(actual()), 32'(rst_word));
    @(posedge clk); #1;
    chk("reset_held", 32'(actual()), 32'(rst_word));
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[k]) begin
      build(vecs[k].op, vecs[k].wf, vecs[k].wm);
      run(vecs[k].op, vecs[k].z, vecs[k].len, vecs[k].name);
    end

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      build(op, $urandom_range(0, 2), $urandom_range(0, 3));
      run(op, 1'($urandom), q.size(), $sformatf("rand%0d_op%b", n, op));
    end

    // Reset raised between edges while a store waits for memory.
    opcode = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memwr_state", 32'(state), 32'd5);
    chk("memwr_write", 32'(mem_write), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_write", 32'(mem_write), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_read", 32'(mem_read), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("refetch_read", 32'(mem_read), 32'd1);
    chk("refetch_irw", 32'(ir_write), 32'd1);
    @(posedge clk); #1;
    chk("refetch_decode", 32'(state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
